// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared D-Mem types, RV64I funct3 codes and load/access helpers.
package as_pack;

  localparam int dmem_aw = 10;

  typedef enum logic [1:0] {IDLE, ACC, RESP} dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Lane-extract a load from a memory double-word; unknown codes return 0.
  function automatic logic [63:0] ld_extend(input logic [63:0] data, input logic [2:0] funct3,
                                            input logic [2:0] off);
    logic [63:0] sh;
    sh = data >> {off, 3'b000};
    case (funct3)
      F3_LB:   return {{56{sh[7]}}, sh[7:0]};
      F3_LH:   return {{48{sh[15]}}, sh[15:0]};
      F3_LW:   return {{32{sh[31]}}, sh[31:0]};
      F3_LD:   return sh;
      F3_LBU:  return {56'b0, sh[7:0]};
      F3_LHU:  return {48'b0, sh[15:0]};
      F3_LWU:  return {32'b0, sh[31:0]};
      default: return 64'b0;
    endcase
  endfunction

  function automatic logic acc_err(input logic we, input logic [2:0] funct3, input logic [2:0] off);
    logic illegal;
    logic mis;
    if (we) illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD});
    else    illegal = (funct3 == 3'b111);
    case (funct3[1:0])
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return illegal | mis;
  endfunction

endpackage

// File: rtl/as_dmem_lane.sv
// rtl/as_dmem_lane.sv - byte enables, store lane shift and load extraction for one access.
module as_dmem_lane
  import as_pack::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata
);

  logic [7:0]  mask;
  logic [63:0] be_bits;

  always_comb begin
    case (funct3[1:0])
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    // Only aligned accesses reach memory, so the shift never spills past lane 7.
    be = mask << off;
    be_bits = '0;
    for (int i = 0; i < 8; i++) be_bits[8*i +: 8] = {8{be[i]}};
    wdata_lane = (wdata << {off, 3'b000}) & be_bits;
    rdata = ld_extend(mem_rdata, funct3, off);
  end

endmodule

// File: rtl/as_dmem_arb.sv
// rtl/as_dmem_arb.sv - two-port (core/debug) D-Mem arbiter with request/access/response sequencing.
module as_dmem_arb
  import as_pack::*;
#(
  parameter int reg_width = 64,
  parameter int max_wait  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 c_req_i,
  input  logic                 c_we_i,
  input  logic [2:0]           c_funct3_i,
  input  logic [dmem_aw+2:0]   c_addr_i,
  input  logic [reg_width-1:0] c_wdata_i,
  output logic                 c_gnt_o,
  output logic                 c_rvalid_o,
  output logic [reg_width-1:0] c_rdata_o,
  output logic                 c_err_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [2:0]           d_funct3_i,
  input  logic [dmem_aw+2:0]   d_addr_i,
  input  logic [reg_width-1:0] d_wdata_i,
  output logic                 d_gnt_o,
  output logic                 d_rvalid_o,
  output logic [reg_width-1:0] d_rdata_o,
  output logic                 d_err_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [7:0]           mem_be_o,
  output logic [dmem_aw-1:0]   mem_addr_o,
  output logic [reg_width-1:0] mem_wdata_o,
  input  logic [reg_width-1:0] mem_rdata_i
);

  localparam int ww = $clog2(max_wait + 1);
  localparam logic [ww-1:0] wait_max = ww'(max_wait);

  dmem_state_t state_q, state_d;
  logic [ww-1:0] wait_cnt;

  logic                 port_q;  // 1 = debug port
  logic                 we_q;
  logic                 err_q;
  logic [2:0]           f3_q;
  logic [dmem_aw+2:0]   addr_q;
  logic [reg_width-1:0] wdata_q;

  logic                 grant;
  logic                 d_win;
  logic                 win_we;
  logic                 win_err;
  logic [2:0]           win_f3;
  logic [dmem_aw+2:0]   win_addr;
  logic [reg_width-1:0] win_wdata;

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    d_win     = d_req_i & (~c_req_i | (wait_cnt == wait_max));
    win_we    = d_win ? d_we_i     : c_we_i;
    win_f3    = d_win ? d_funct3_i : c_funct3_i;
    win_addr  = d_win ? d_addr_i   : c_addr_i;
    win_wdata = d_win ? d_wdata_i  : c_wdata_i;
    win_err   = acc_err(win_we, win_f3, win_addr[2:0]);
    case (state_q)
      IDLE: begin
        if ((c_req_i | d_req_i) & ~rst_i) begin
          grant   = 1'b1;
          state_d = win_err ? RESP : ACC;
        end
      end
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q  <= d_win;
        we_q    <= win_we;
        err_q   <= win_err;
        f3_q    <= win_f3;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      // Debug port loses only while core wins; saturate so it wins at the limit.
      if (grant & d_win)
        wait_cnt <= '0;
      else if (grant & d_req_i & (wait_cnt != wait_max))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  logic [7:0]  lane_be;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;

  as_dmem_lane u_lane (
    .funct3     (f3_q),
    .off        (addr_q[2:0]),
    .wdata      (wdata_q),
    .mem_rdata  (mem_rdata_i),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata      (lane_rdata)
  );

  logic acc;
  logic resp;
  logic ld_ok;

  assign acc   = (state_q == ACC);
  assign resp  = (state_q == RESP);
  assign ld_ok = resp & ~we_q & ~err_q;

  assign c_gnt_o     = grant & ~d_win;
  assign d_gnt_o     = grant & d_win;
  assign mem_en_o    = acc;
  assign mem_we_o    = acc & we_q;
  assign mem_be_o    = acc ? lane_be : 8'h00;
  assign mem_addr_o  = acc ? addr_q[dmem_aw+2:3] : '0;
  assign mem_wdata_o = acc ? lane_wdata : '0;
  assign c_rvalid_o  = resp & ~port_q;
  assign d_rvalid_o  = resp & port_q;
  assign c_err_o     = resp & ~port_q & err_q;
  assign d_err_o     = resp & port_q & err_q;
  assign c_rdata_o   = (ld_ok & ~port_q) ? lane_rdata : '0;
  assign d_rdata_o   = (ld_ok & port_q) ? lane_rdata : '0;

endmodule

// File: tb/tb_as_dmem_arb.sv
// tb/tb_as_dmem_arb.sv - table-driven scoreboard bench for as_dmem_arb.
module tb_as_dmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_f3, d_f3;
  logic [12:0] c_addr, d_addr;
  logic [63:0] c_wdata, d_wdata;
  logic        c_gnt_o, c_rvalid_o, c_err_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic [63:0] c_rdata_o, d_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_be_o;
  logic [9:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;

  as_dmem_arb dut (
    .clk_i(clk), .rst_i(rst),
    .c_req_i(c_req), .c_we_i(c_we), .c_funct3_i(c_f3), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o), .c_err_o(c_err_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_funct3_i(d_f3), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [12:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  be;
    logic [63:0] mwd;
  } vec_t;

  typedef struct {
    logic        port;
    logic        we;
    logic        err;
    logic [63:0] rdata;
    logic [7:0]  be;
    logic [63:0] mwd;
    logic [9:0]  maddr;
    int          gcyc;
  } exp_t;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t resp_q[$];
  exp_t mem_q[$];
  int   glog[$];
  logic [63:0] mem [0:1023];
  vec_t vecs[17];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= mem[mem_addr_o];
      if (mem_we_o)
        for (int b = 0; b < 8; b++)
          if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (c_gnt_o) glog.push_back(0);
      if (d_gnt_o) glog.push_back(1);
      if (c_gnt_o && d_gnt_o) check("dual_gnt", 64'(d_gnt_o), 64'(0));
      if (mem_en_o) begin
        if (mem_q.size() == 0) check("unexp_mem_en", 64'(mem_en_o), 64'(0));
        else begin
          e = mem_q.pop_front();
          check("mem_we", 64'(mem_we_o), 64'(e.we));
          check("mem_be", 64'(mem_be_o), 64'(e.be));
          check("mem_addr", 64'(mem_addr_o), 64'(e.maddr));
          if (e.we) check("mem_wdata", mem_wdata_o, e.mwd);
          check("mem_lat", 64'(cyc), 64'(e.gcyc + 1));
        end
      end
      if (c_rvalid_o || d_rvalid_o) begin
        check("rv_excl", 64'(c_rvalid_o & d_rvalid_o), 64'(0));
        if (resp_q.size() == 0) check("unexp_rvalid", 64'(1), 64'(0));
        else begin
          e = resp_q.pop_front();
          check("rv_port", 64'(d_rvalid_o), 64'(e.port));
          check("rdata", e.port ? d_rdata_o : c_rdata_o, e.rdata);
          check("err", 64'(e.port ? d_err_o : c_err_o), 64'(e.err));
          check("rv_lat", 64'(cyc), 64'(e.gcyc + (e.err ? 1 : 2)));
        end
      end
    end
  end

  task automatic access(input vec_t v);
    bit   got = 0;
    exp_t e;
    @(posedge clk); #1;
    if (v.port) begin
      d_req = 1; d_we = v.we; d_f3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1; c_we = v.we; c_f3 = v.f3; c_addr = v.addr; c_wdata = v.wdata;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if ((v.port ? d_gnt_o : c_gnt_o) === 1'b1) begin
        got = 1;
        e = '{v.port, v.we, v.err, v.rdata, v.be, v.mwd, v.addr[12:3], cyc};
        resp_q.push_back(e);
        if (!v.err) mem_q.push_back(e);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL gnt_timeout: port %0d got no grant, required one", v.port);
    end
    @(posedge clk); #1;
    if (v.port) d_req = 0; else c_req = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 20) begin
      @(negedge clk); n++;
    end
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", resp_q.size());
      resp_q.delete(); mem_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    vec_t vc, vd;
    int   gexp[7];
    rst = 1; c_req = 0; d_req = 0; c_we = 0; d_we = 0; c_f3 = 0; d_f3 = 0;
    c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0; mem_rdata_i = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    mem[0] = 64'h8000_0000_0000_0000;
    mem[1] = 64'hFEDC_BA98_7654_3210;
    mem[3] = 64'h0123_4567_89AB_CDEF;

    //          port we  f3      addr    wdata                   rdata                   err be     mwd
    vecs[0]  = '{0, 0, 3'b000, 13'h07, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 0, 8'h80, 64'h0};
    vecs[1]  = '{0, 0, 3'b100, 13'h07, 64'h0,                  64'h0000_0000_0000_0080, 0, 8'h80, 64'h0};
    vecs[2]  = '{0, 1, 3'b001, 13'h06, 64'h1234,               64'h0,                   0, 8'hC0, 64'h1234_0000_0000_0000};
    vecs[3]  = '{0, 0, 3'b010, 13'h02, 64'h0,                  64'h0,                   1, 8'h00, 64'h0};
    vecs[4]  = '{1, 0, 3'b011, 13'h18, 64'h0,                  64'h0123_4567_89AB_CDEF, 0, 8'hFF, 64'h0};
    vecs[5]  = '{0, 0, 3'b010, 13'h0C, 64'h0,                  64'hFFFF_FFFF_FEDC_BA98, 0, 8'hF0, 64'h0};
    vecs[6]  = '{0, 0, 3'b110, 13'h0C, 64'h0,                  64'h0000_0000_FEDC_BA98, 0, 8'hF0, 64'h0};
    vecs[7]  = '{1, 0, 3'b001, 13'h06, 64'h0,                  64'h0000_0000_0000_1234, 0, 8'hC0, 64'h0};
    vecs[8]  = '{0, 1, 3'b011, 13'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                  0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[9]  = '{0, 0, 3'b011, 13'h10, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 0, 8'hFF, 64'h0};
    vecs[10] = '{0, 1, 3'b100, 13'h10, 64'h55,                 64'h0,                   1, 8'h00, 64'h0};
    vecs[11] = '{0, 0, 3'b111, 13'h00, 64'h0,                  64'h0,                   1, 8'h00, 64'h0};
    vecs[12] = '{1, 1, 3'b010, 13'h14, 64'h1122_3344_5566_7788, 64'h0,                  0, 8'hF0, 64'h5566_7788_0000_0000};
    vecs[13] = '{1, 0, 3'b000, 13'h15, 64'h0,                  64'h0000_0000_0000_0077, 0, 8'h20, 64'h0};
    vecs[14] = '{0, 0, 3'b001, 13'h03, 64'h0,                  64'h0,                   1, 8'h00, 64'h0};
    vecs[15] = '{0, 0, 3'b101, 13'h1E, 64'h0,                  64'h0000_0000_0000_0123, 0, 8'hC0, 64'h0};
    vecs[16] = '{0, 0, 3'b001, 13'h0E, 64'h0,                  64'hFFFF_FFFF_FFFF_FEDC, 0, 8'hC0, 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 64'(mem_en_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_mem_be", 64'(mem_be_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_mem_wdata", mem_wdata_o, 64'(0));
    check("rst_rvalid", 64'({c_rvalid_o, d_rvalid_o}), 64'(0));
    check("rst_rdata", c_rdata_o | d_rdata_o, 64'(0));
    check("rst_gnt", 64'({c_gnt_o, d_gnt_o}), 64'(0));
    @(posedge clk); #1; rst = 0;

    for (int i = 0; i < 17; i++) begin
      access(vecs[i]);
      drain();
    end

    // Reset pulse while the access is in ACC must abort it.
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_f3 = 3'b011; c_addr = 13'h18; c_wdata = 0;
    @(negedge clk);
    check("rstacc_gnt", 64'(c_gnt_o), 64'(1));
    e = '{0, 0, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 10'd3, cyc};
    mem_q.push_back(e);
    @(posedge clk); #1; c_req = 0;
    @(negedge clk);
    check("rstacc_en", 64'(mem_en_o), 64'(1));
    #2; rst = 1; #1;
    check("rstacc_async_en", 64'(mem_en_o), 64'(0));
    check("rstacc_async_be", 64'(mem_be_o), 64'(0));
    @(posedge clk); #1; rst = 0;
    repeat (4) @(negedge clk);
    access(vecs[4]);
    drain();

    // Both ports requesting back to back: debug wins on the fifth grant.
    vc = '{0, 0, 3'b011, 13'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 8'hFF, 64'h0};
    vd = '{1, 0, 3'b011, 13'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 8'hFF, 64'h0};
    glog.delete();
    fork
      begin repeat (5) access(vc); end
      begin repeat (2) access(vd); end
    join
    drain();
    gexp = '{0, 0, 0, 0, 1, 0, 1};
    check("starv_len", 64'(glog.size()), 64'(7));
    for (int i = 0; i < 7; i++)
      check($sformatf("starv_gnt%0d", i), 64'(i < glog.size() ? glog[i] : -1), 64'(gexp[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
